// File: rtl/pipe_ctrl_if.sv
//==============================================================================
// Module : pipe_ctrl_if
// Brief  : Hazard inputs and stage-control outputs of the pipeline controller.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pipe_ctrl_if;
  logic [31:0] ID_Instr;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic [4:0]  EX_Rt;
  logic        EX_MemtoReg;
  logic        EX_MdOp;
  logic        M_Branch;
  logic        M_Zero;

  logic        PC_EN;
  logic        IFID_EN;
  logic        IDEX_EN;
  logic        FLUSH_IFID;
  logic        FLUSH_IDEX;
  logic        FLUSH_EXMEM;
  logic        PCSRC;
  logic        HALTED;
  logic [1:0]  STATE;
  logic [15:0] STALL_CNT;
  logic [15:0] FLUSH_CNT;

  // The controller is the slave: it observes hazards and drives stage controls.
  modport slave (
    input  ID_Instr, ID_Rs, ID_Rt, EX_Rt, EX_MemtoReg, EX_MdOp, M_Branch, M_Zero,
    output PC_EN, IFID_EN, IDEX_EN, FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM,
           PCSRC, HALTED, STATE, STALL_CNT, FLUSH_CNT
  );

  modport master (
    output ID_Instr, ID_Rs, ID_Rt, EX_Rt, EX_MemtoReg, EX_MdOp, M_Branch, M_Zero,
    input  PC_EN, IFID_EN, IDEX_EN, FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM,
           PCSRC, HALTED, STATE, STALL_CNT, FLUSH_CNT
  );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//==============================================================================
// Module : pipe_ctrl
// Brief  : 5-stage pipeline hazard controller (branch flush, mul/div stall,
//          load-use bubble, halt drain) with saturating perf counters.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_ctrl (
  input  wire logic  CLK,
  input  wire logic  RESET,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MDWAIT = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam logic [1:0]  CNT_START = 2'd2;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic taken;
  logic load_use;
  logic halt_word;
  logic stall_inc;
  logic flush_inc;

  logic pc_en, ifid_en, idex_en;
  logic flush_ifid, flush_idex, flush_exmem;
  logic pcsrc, halted;

  always_comb begin
    taken     = bus.M_Branch & bus.M_Zero;
    load_use  = bus.EX_MemtoReg && (bus.EX_Rt != 5'd0) &&
                ((bus.EX_Rt == bus.ID_Rs) || (bus.EX_Rt == bus.ID_Rt));
    halt_word = (bus.ID_Instr == 32'hFFFF_FFFF);

    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    pcsrc       = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (state_q == ST_HALT) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
      halted  = 1'b1;
    end else if (taken) begin
      // A taken branch squashes everything younger, including a pending halt.
      pcsrc       = 1'b1;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      state_d     = ST_RUN;
      cnt_d       = 2'd0;
      flush_inc   = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.EX_MdOp) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            flush_exmem = 1'b1;
            state_d     = ST_MDWAIT;
            cnt_d       = CNT_START;
            stall_inc   = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            flush_idex = 1'b1;
            stall_inc  = 1'b1;
          end else if (halt_word) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            flush_idex = 1'b1;
            state_d    = ST_DRAIN;
            cnt_d      = CNT_START;
          end
        end
        ST_MDWAIT: begin
          if (cnt_q != 2'd0) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            flush_exmem = 1'b1;
            cnt_d       = cnt_q - 2'd1;
            stall_inc   = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          flush_idex = 1'b1;
          if (cnt_q == 2'd0) begin
            state_d = ST_HALT;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end

    stall_cnt_d = (stall_inc && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PC_EN       = pc_en;
  assign bus.IFID_EN     = ifid_en;
  assign bus.IDEX_EN     = idex_en;
  assign bus.FLUSH_IFID  = flush_ifid;
  assign bus.FLUSH_IDEX  = flush_idex;
  assign bus.FLUSH_EXMEM = flush_exmem;
  assign bus.PCSRC       = pcsrc;
  assign bus.HALTED      = halted;
  assign bus.STATE       = state_q;
  assign bus.STALL_CNT   = stall_cnt_q;
  assign bus.FLUSH_CNT   = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
//==============================================================================
// Module : tb_pipe_ctrl
// Brief  : Self-checking bench for pipe_ctrl against a timeline-based model.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_ctrl;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct packed {
    logic        rst;
    logic [31:0] instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  ex_rt;
    logic        mtr;
    logic        md;
    logic        br;
    logic        z;
  } stim_t;

  stim_t s;
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last_obs;

  // Model: mode 0=running, 1=mul/div in EX, 2=draining, 3=halted.
  // age counts cycles already spent in the current multi-cycle mode.
  int m_mode    = 0;
  int m_age     = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  // Output vector order: PC_EN IFID_EN IDEX_EN FL_IFID FL_IDEX FL_EXMEM PCSRC HALTED
  localparam logic [7:0] O_DEFAULT = 8'b1110_0000;
  localparam logic [7:0] O_BRANCH  = 8'b1111_1110;
  localparam logic [7:0] O_MDSTALL = 8'b0000_0100;
  localparam logic [7:0] O_BUBBLE  = 8'b0010_1000;
  localparam logic [7:0] O_HALT    = 8'b0000_0001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t r;
    r = '0;
    return r;
  endfunction

  function automatic int bump(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic tick(input bit do_chk);
    logic [7:0] e, o;
    bit taken, lu, hlt;
    int nmode, nage, nst, nfl;
    @(negedge CLK);
    RESET           = s.rst;
    bus.ID_Instr    = s.instr;
    bus.ID_Rs       = s.rs;
    bus.ID_Rt       = s.rt;
    bus.EX_Rt       = s.ex_rt;
    bus.EX_MemtoReg = s.mtr;
    bus.EX_MdOp     = s.md;
    bus.M_Branch    = s.br;
    bus.M_Zero      = s.z;
    #1;
    taken = s.br && s.z;
    lu    = s.mtr && (s.ex_rt != 0) && ((s.ex_rt == s.rs) || (s.ex_rt == s.rt));
    hlt   = (s.instr == 32'hFFFF_FFFF);
    e = O_DEFAULT; nmode = m_mode; nage = m_age; nst = m_stalls; nfl = m_flushes;
    if (m_mode == 3) begin
      e = O_HALT;
    end else if (taken) begin
      e = O_BRANCH; nmode = 0; nage = 0; nfl = bump(m_flushes);
    end else if (m_mode == 0) begin
      if (s.md) begin
        e = O_MDSTALL; nmode = 1; nage = 0; nst = bump(m_stalls);
      end else if (lu) begin
        e = O_BUBBLE; nst = bump(m_stalls);
      end else if (hlt) begin
        e = O_BUBBLE; nmode = 2; nage = 0;
      end
    end else if (m_mode == 1) begin
      // An MD op sits 4 cycles in EX: start + two waits stalled, then release.
      if (m_age < 2) begin
        e = O_MDSTALL; nage = m_age + 1; nst = bump(m_stalls);
      end else begin
        nmode = 0;
      end
    end else begin
      // Drain spans 3 cycles so EX, MEM and WB retire before halting.
      e = O_BUBBLE;
      if (m_age == 2) nmode = 3;
      else nage = m_age + 1;
    end
    o = {bus.PC_EN, bus.IFID_EN, bus.IDEX_EN, bus.FLUSH_IFID, bus.FLUSH_IDEX,
         bus.FLUSH_EXMEM, bus.PCSRC, bus.HALTED};
    last_obs = o;
    if (do_chk) begin
      chk("outs", 32'(o), 32'(e));
      chk("state", 32'(bus.STATE), 32'(m_mode));
      chk("stall_cnt", 32'(bus.STALL_CNT), 32'(m_stalls));
      chk("flush_cnt", 32'(bus.FLUSH_CNT), 32'(m_flushes));
    end
    if (s.rst) begin
      m_mode = 0; m_age = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      m_mode = nmode; m_age = nage; m_stalls = nst; m_flushes = nfl;
    end
  endtask

  task automatic do_reset();
    s = idle();
    s.rst = 1'b1;
    tick(1'b1);
    s = idle();
  endtask

  initial begin
    int zero_pc;
    s = idle();
    s.rst = 1'b1;
    tick(1'b0);
    s = idle();

    // Reset state
    tick(1'b1);
    chk("rst_outs", 32'(last_obs), 32'(O_DEFAULT));
    chk("rst_state", 32'(bus.STATE), 32'd0);

    // Load-use bubble, then the same pattern on r0
    s.mtr = 1'b1; s.ex_rt = 5'd5; s.rs = 5'd5;
    tick(1'b1);
    chk("lu_outs", 32'(last_obs), 32'(O_BUBBLE));
    s = idle();
    tick(1'b1);
    chk("lu_stall_cnt", 32'(bus.STALL_CNT), 32'd1);
    s.mtr = 1'b1; s.ex_rt = 5'd0; s.rs = 5'd0;
    tick(1'b1);
    chk("lu_r0_outs", 32'(last_obs), 32'(O_DEFAULT));

    // MD held: three stalled cycles then a release cycle
    do_reset();
    s.md = 1'b1;
    zero_pc = 0;
    repeat (3) begin
      tick(1'b1);
      if (last_obs[7] == 1'b0) zero_pc++;
    end
    chk("md_stall_cycles", 32'(zero_pc), 32'd3);
    tick(1'b1);
    chk("md_release_pc", 32'(last_obs[7]), 32'd1);
    s = idle();
    tick(1'b1);
    chk("md_stall_cnt", 32'(bus.STALL_CNT), 32'd3);

    // Branch in second MDWAIT cycle
    do_reset();
    s.md = 1'b1;
    tick(1'b1);
    s = idle();
    tick(1'b1);
    s.br = 1'b1; s.z = 1'b1;
    tick(1'b1);
    chk("br_md_outs", 32'(last_obs), 32'(O_BRANCH));
    s = idle();
    tick(1'b1);
    chk("br_md_state", 32'(bus.STATE), 32'd0);
    chk("br_md_flush_cnt", 32'(bus.FLUSH_CNT), 32'd1);

    // Halt: three drain cycles, then halted even under a taken branch
    do_reset();
    s.instr = 32'hFFFF_FFFF;
    tick(1'b1);
    s = idle();
    repeat (3) begin
      tick(1'b1);
      chk("drain_state", 32'(bus.STATE), 32'd2);
    end
    s.br = 1'b1; s.z = 1'b1;
    repeat (3) begin
      tick(1'b1);
      chk("halt_state", 32'(bus.STATE), 32'd3);
      chk("halt_outs", 32'(last_obs), 32'(O_HALT));
    end

    // Squashed halt
    do_reset();
    s.instr = 32'hFFFF_FFFF;
    tick(1'b1);
    s = idle();
    s.br = 1'b1; s.z = 1'b1;
    tick(1'b1);
    chk("sq_pcsrc", 32'(last_obs[1]), 32'd1);
    s = idle();
    repeat (4) begin
      tick(1'b1);
      chk("sq_state", 32'(bus.STATE), 32'd0);
      chk("sq_halted", 32'(last_obs[0]), 32'd0);
    end

    // Reset in MDWAIT with CNT=1 and STALL_CNT=7
    do_reset();
    s.mtr = 1'b1; s.ex_rt = 5'd3; s.rt = 5'd3;
    repeat (5) tick(1'b1);
    s = idle();
    s.md = 1'b1;
    tick(1'b1);
    s = idle();
    tick(1'b1);
    s.rst = 1'b1;
    tick(1'b1);
    chk("mid_md_state", 32'(bus.STATE), 32'd1);
    chk("mid_md_stall_cnt", 32'(bus.STALL_CNT), 32'd7);
    s = idle();
    tick(1'b1);
    chk("post_rst_state", 32'(bus.STATE), 32'd0);
    chk("post_rst_stall_cnt", 32'(bus.STALL_CNT), 32'd0);
    chk("post_rst_pc_en", 32'(last_obs[7]), 32'd1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      s = idle();
      s.instr = ($urandom_range(0, 29) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.ex_rt = 5'($urandom_range(0, 3));
      s.mtr   = ($urandom_range(0, 2) == 0);
      s.md    = ($urandom_range(0, 5) == 0);
      s.br    = ($urandom_range(0, 1) == 0);
      s.z     = ($urandom_range(0, 3) == 0);
      s.rst   = ((m_mode == 3) && ($urandom_range(0, 5) == 0)) || ($urandom_range(0, 199) == 0);
      tick(1'b1);
    end

    // Stall counter saturation under a continuous load-use hazard
    do_reset();
    s.mtr = 1'b1; s.ex_rt = 5'd7; s.rs = 5'd7;
    repeat (65540) tick(1'b0);
    tick(1'b1);
    chk("stall_sat", 32'(bus.STALL_CNT), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have the following ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- ID_Instr  in  32  instruction word in the decode stage.
- ID_Rs, ID_Rt  in  5 each  source register fields in decode.
- EX_Rt  in  5  Rt of the instruction in execute.
- EX_MemtoReg  in  1  execute-stage instruction is a load.
- EX_MdOp  in  1  execute-stage instruction is a multi-cycle mul/div.
- M_Branch, M_Zero  in  1 each  branch flag and ALU zero, memory stage.
- PC_EN  out  1  PC register write enable.
- IFID_EN  out  1  IF/ID register write enable.
- IDEX_EN  out  1  ID/EX register write enable.
- FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM  out  1 each  synchronous bubble insert into the named stage register.
- PCSRC  out  1  selects branch target for the next PC.
- HALTED  out  1  pipeline fully drained and stopped.
- STATE  out  2  FSM state: RUN=0, MDWAIT=1, DRAIN=2, HALT=3.
- STALL_CNT  out  16  stalled-cycle count.
- FLUSH_CNT  out  16  taken-branch count.
REQ-002 SHALL use reset RESET, synchronous, active-high; clock CLK.

Function
REQ-003 SHALL drive all outputs combinationally from STATE, the internal counter CNT[1:0] and the inputs; STATE, CNT and the perf counters are registered.
REQ-004 SHALL define the default outputs as PC_EN=IFID_EN=IDEX_EN=1, all FLUSH_* =0, PCSRC=0 and HALTED=0.
REQ-005 SHALL detect a taken branch as TB = M_Branch & M_Zero; in any state except HALT, TB SHALL force the following:
- PCSRC=1 and PC_EN=1.
- FLUSH_IFID=FLUSH_IDEX=FLUSH_EXMEM=1.
- Next state RUN, CNT=0, FLUSH_CNT increments.
REQ-006 SHALL apply the following priority in RUN: TB, then MD start, then load-use, then halt detect.
REQ-007 SHALL detect MD start in RUN when EX_MdOp=1, and SHALL respond as follows:
- PC_EN=IFID_EN=IDEX_EN=0, FLUSH_EXMEM=1.
- Next state MDWAIT with CNT=2, STALL_CNT increments.
REQ-008 SHALL behave in MDWAIT (without TB) as follows, ignoring EX_MdOp throughout:
- If CNT!=0: same stall outputs as REQ-007, CNT decrements, STALL_CNT increments.
- If CNT==0: default outputs (release cycle), next state RUN.
- An MD op therefore occupies EX for exactly 4 cycles, 3 of them stalled.
REQ-009 SHALL detect load-use in RUN when EX_MemtoReg=1, EX_Rt!=0 and (EX_Rt==ID_Rs or EX_Rt==ID_Rt), and SHALL respond as follows:
- PC_EN=IFID_EN=0, FLUSH_IDEX=1, STALL_CNT increments, state stays RUN.
- A single bubble results, since the load leaves EX on the next edge.
REQ-010 SHALL detect halt in RUN when ID_Instr==32'hFFFFFFFF, and SHALL respond as follows:
- PC_EN=IFID_EN=0, FLUSH_IDEX=1.
- Next state DRAIN with CNT=2.
REQ-011 SHALL behave in DRAIN (without TB) as follows:
- PC_EN=IFID_EN=0, FLUSH_IDEX=1.
- CNT decrements; at CNT==0 next state HALT.
- DRAIN lasts 3 cycles so that the older EX, MEM and WB instructions retire.
REQ-012 SHALL return to RUN on TB during DRAIN, because the halt word is younger than the branch and is squashed.
REQ-013 SHALL drive HALTED=1 and PC_EN=IFID_EN=IDEX_EN=0 in HALT, with flushes 0 and PCSRC=0; TB is ignored and HALT persists until RESET.
REQ-014 SHALL saturate STALL_CNT and FLUSH_CNT at 16'hFFFF, with no wrap.
REQ-015 SHALL NOT increment STALL_CNT in a TB cycle.

Reset
REQ-016 SHALL set the following on a posedge with RESET=1, overriding all inputs including TB:
- STATE=RUN, CNT=0, STALL_CNT=0, FLUSH_CNT=0.
- Outputs take their RUN-state values in the following cycle.
REQ-017 SHALL abort MDWAIT or DRAIN on reset mid-operation, with no residual stall after reset.

Verification
REQ-018 SHALL pass load-use: EX_MemtoReg=1, EX_Rt=5, ID_Rs=5 in RUN -> one cycle with PC_EN=0, IFID_EN=0, FLUSH_IDEX=1; STALL_CNT 0->1; the same pattern with EX_Rt=0 -> no stall.
REQ-019 SHALL pass MD: EX_MdOp=1 held -> PC_EN=0 for 3 consecutive cycles, STATE=1 for 3 cycles, then one release cycle with PC_EN=1; STALL_CNT=3.
REQ-020 SHALL pass branch over MD: TB=1 in the second MDWAIT cycle -> that cycle has PCSRC=1 and all flushes 1; next STATE=RUN; FLUSH_CNT=1.
REQ-021 SHALL pass halt: ID_Instr=FFFFFFFF -> STATE=2 for 3 cycles, then STATE=3 with HALTED=1; HALTED stays 1 with TB=1 applied.
REQ-022 SHALL pass squashed halt: TB=1 during the first DRAIN cycle -> PCSRC=1, next STATE=RUN, HALTED never asserted.
REQ-023 SHALL pass reset: RESET=1 while in MDWAIT with CNT=1 and STALL_CNT=7 -> next cycle STATE=0, STALL_CNT=0, PC_EN=1.
